// File: rtl/spi_target.sv
// SPI mode-0 target (MSB first) sampled in the clk domain: synchronized pins,
// edge detection, byte-wide rx/tx shifting with a one-deep transmit holding register.
module spi_target #(
   parameter logic [7:0]  FILL        = 8'hFF,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sclk,
   input  logic       cs_n,
   input  logic       mosi,
   output logic       miso,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       overrun,
   input  logic       ovr_clr,
   output logic       busy
);

   localparam int unsigned DW = 8;
   localparam int unsigned CW = 3;
   localparam int unsigned SW = SYNC_STAGES;

   typedef enum logic {IDLE, ACTIVE} state_t;

   // Pin synchronizers plus one delayed copy for edge detection
   logic [SW-1:0] sclk_sync, cs_sync, mosi_sync;
   logic          sclk_d, cs_d;
   logic          sclk_s, cs_s, mosi_s;
   logic          sclk_rise, sclk_fall, cs_fall, cs_rise;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sync <= '0;
         cs_sync   <= '1;
         mosi_sync <= '1;
         sclk_d    <= 1'b0;
         cs_d      <= 1'b1;
      end else begin
         sclk_sync <= {sclk_sync[SW-2:0], sclk};
         cs_sync   <= {cs_sync[SW-2:0], cs_n};
         mosi_sync <= {mosi_sync[SW-2:0], mosi};
         sclk_d    <= sclk_s;
         cs_d      <= cs_s;
      end
   end

   assign sclk_s    = sclk_sync[SW-1];
   assign cs_s      = cs_sync[SW-1];
   assign mosi_s    = mosi_sync[SW-1];
   assign sclk_rise = sclk_s & ~sclk_d;
   assign sclk_fall = ~sclk_s & sclk_d;
   assign cs_fall   = ~cs_s & cs_d;
   assign cs_rise   = cs_s & ~cs_d;

   state_t        state_q, state_d;
   logic [CW-1:0] bit_cnt_q, bit_cnt_d;
   logic [DW-1:0] rx_shift_q, rx_shift_d;
   logic [DW-1:0] tx_shift_q, tx_shift_d;
   logic [DW-1:0] hold_data_q, hold_data_d;
   logic          hold_full_q, hold_full_d;
   logic          done_q, done_d;
   logic [DW-1:0] rx_data_d;
   logic          rx_valid_d, overrun_d, miso_d, busy_d, tx_ready_d;
   logic          load, capture, ovr_set;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         bit_cnt_q   <= '0;
         rx_shift_q  <= '0;
         tx_shift_q  <= '0;
         hold_data_q <= '0;
         hold_full_q <= 1'b0;
         done_q      <= 1'b0;
         rx_data     <= '0;
         rx_valid    <= 1'b0;
         overrun     <= 1'b0;
         miso        <= 1'b1;
         busy        <= 1'b0;
         tx_ready    <= 1'b1;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         rx_shift_q  <= rx_shift_d;
         tx_shift_q  <= tx_shift_d;
         hold_data_q <= hold_data_d;
         hold_full_q <= hold_full_d;
         done_q      <= done_d;
         rx_data     <= rx_data_d;
         rx_valid    <= rx_valid_d;
         overrun     <= overrun_d;
         miso        <= miso_d;
         busy        <= busy_d;
         tx_ready    <= tx_ready_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      rx_shift_d  = rx_shift_q;
      tx_shift_d  = tx_shift_q;
      hold_data_d = hold_data_q;
      hold_full_d = hold_full_q;
      done_d      = 1'b0;
      rx_data_d   = rx_data;
      rx_valid_d  = rx_valid;
      load        = 1'b0;
      capture     = 1'b0;
      ovr_set     = 1'b0;

      case (state_q)
         IDLE: begin
            if (cs_fall) begin
               state_d   = ACTIVE;
               bit_cnt_d = '0;
               load      = 1'b1;
            end
         end
         ACTIVE: begin
            if (cs_rise) begin
               state_d   = IDLE;
               bit_cnt_d = '0;
            end else if (sclk_rise) begin
               rx_shift_d = {rx_shift_q[DW-2:0], mosi_s};
               bit_cnt_d  = bit_cnt_q + CW'(1);
               done_d     = (bit_cnt_q == CW'(DW - 1));
            end else if (sclk_fall) begin
               if (bit_cnt_q != '0) tx_shift_d = {tx_shift_q[DW-2:0], 1'b0};
               else                 load       = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Byte boundary: next tx byte comes from the holding register, else FILL
      if (load) tx_shift_d = hold_full_q ? hold_data_q : FILL;

      capture     = tx_valid & ~hold_full_q;
      hold_full_d = capture | (hold_full_q & ~load);
      if (capture) hold_data_d = tx_data;

      // rx_shift_q holds the completed byte for the cycle after the wrap
      if (done_q) begin
         if (rx_valid & ~rx_ready) begin
            ovr_set = 1'b1;
         end else begin
            rx_data_d  = rx_shift_q;
            rx_valid_d = 1'b1;
         end
      end else if (rx_valid & rx_ready) begin
         rx_valid_d = 1'b0;
      end

      overrun_d  = ovr_set | (overrun & ~ovr_clr);
      miso_d     = (state_d == ACTIVE) ? tx_shift_d[DW-1] : 1'b1;
      busy_d     = (state_d == ACTIVE);
      tx_ready_d = ~hold_full_d;
   end

endmodule
